// File: rtl/collector_mc_pkg.sv
// Shared types and constants for the multi-channel AXI-S receive collector.
package collector_mc_pkg;

    localparam int DROP_CNT_W = 32;
    localparam int DEF_DATAW  = 512;

    typedef struct packed {
        logic                 last;
        logic [DEF_DATAW-1:0] data;
    } fifo_entry_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/collector_mc_chan.sv
// One collector channel: show-ahead FIFO of {last, data} words plus the
// occupancy/packet counters that drive its ready and accept flags.
module collector_chan #(
    parameter int DATAW     = 512,
    parameter int DEPTH     = 64,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int STORE_FWD = 0,
    parameter int OCCW      = 7
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_push,
    input  logic [DATAW:0] i_entry,
    input  logic           i_pop,
    output logic [DATAW:0] o_entry,
    output logic           o_rdy,
    output logic           o_accept
);

    localparam int AW = $clog2(DEPTH);

    logic [DATAW:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [OCCW-1:0] r_occ;
    logic [OCCW-1:0] r_pkt;
    logic            w_rdy_raw;
    logic            w_pop;
    logic            w_push_last;
    logic            w_pop_last;

    // Ready: cut-through shows any word; store-and-forward needs a whole
    // packet, or an almost-full channel so over-long packets still drain.
    always_comb begin
        w_rdy_raw = 1'b0;
        if (STORE_FWD != 0) begin
            w_rdy_raw = (r_pkt != {OCCW{1'b0}}) || (r_occ >= OCCW'(AF_LEVEL));
        end else begin
            w_rdy_raw = (r_occ != {OCCW{1'b0}});
        end
    end

    assign o_rdy       = w_rdy_raw && !i_rst;
    assign o_accept    = (r_occ < OCCW'(AF_LEVEL));
    assign o_entry     = r_mem[r_rptr];
    assign w_pop       = i_pop && o_rdy;
    assign w_push_last = i_push && i_entry[DATAW];
    assign w_pop_last  = w_pop && o_entry[DATAW];

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    // Pointers and counters; simultaneous push and pop cancel in the counts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= {AW{1'b0}};
            r_rptr <= {AW{1'b0}};
            r_occ  <= {OCCW{1'b0}};
            r_pkt  <= {OCCW{1'b0}};
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1'b1);
            end
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + OCCW'(1'b1);
                2'b01:   r_occ <= r_occ - OCCW'(1'b1);
                default: r_occ <= r_occ;
            endcase
            case ({w_push_last, w_pop_last})
                2'b10:   r_pkt <= r_pkt + OCCW'(1'b1);
                2'b01:   r_pkt <= r_pkt - OCCW'(1'b1);
                default: r_pkt <= r_pkt;
            endcase
        end
    end

endmodule

// File: rtl/collector_mc.sv
// Multi-channel AXI-S receive collector: steers beats by tdest into
// per-channel FIFOs and counts beats addressed to non-existent channels.
module collector_mc
    import collector_mc_pkg::*;
#(
    parameter int DATAW     = DEF_DATAW,
    parameter int BYTEW     = 8,
    parameter int IDW       = 32,
    parameter int DESTW     = 7,
    parameter int USERW     = 75,
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 64,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int STORE_FWD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    axis_rx_tvalid,
    input  logic [DATAW-1:0]        axis_rx_tdata,
    input  logic [BYTEW-1:0]        axis_rx_tstrb,
    input  logic [BYTEW-1:0]        axis_rx_tkeep,
    input  logic [IDW-1:0]          axis_rx_tid,
    input  logic [DESTW-1:0]        axis_rx_tdest,
    input  logic [USERW-1:0]        axis_rx_tuser,
    input  logic                    axis_rx_tlast,
    output logic                    axis_rx_tready,
    input  logic [NUM_CH-1:0]       data_fifo_ren,
    output logic [NUM_CH*DATAW-1:0] data_fifo_rdata,
    output logic [NUM_CH-1:0]       data_fifo_rlast,
    output logic [NUM_CH-1:0]       data_fifo_rdy,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int OCCW = occ_width(DEPTH);

    logic [NUM_CH-1:0]     w_accept;
    logic [NUM_CH-1:0]     w_push;
    logic [DATAW:0]        w_head [NUM_CH];
    logic                  w_hit;
    logic                  w_sel_accept;
    logic                  w_fire;
    logic                  w_drop;
    logic                  w_unused;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_unused = ^{axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid, axis_rx_tuser};

    // tdest decode; a loop compare copes with NUM_CH that is not a power of 2.
    always_comb begin
        w_hit        = 1'b0;
        w_sel_accept = 1'b0;
        w_push       = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            w_hit        = w_hit | (axis_rx_tdest == DESTW'(c));
            w_sel_accept = w_sel_accept | ((axis_rx_tdest == DESTW'(c)) & w_accept[c]);
            w_push[c]    = w_fire & (axis_rx_tdest == DESTW'(c));
        end
    end

    assign axis_rx_tready = rst ? 1'b0 : (w_hit ? w_sel_accept : 1'b1);
    assign w_fire         = axis_rx_tvalid && axis_rx_tready;
    assign w_drop         = w_fire && !w_hit;

    // Saturating count of beats discarded for out-of-range tdest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= {DROP_CNT_W{1'b0}};
        end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1'b1);
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        collector_chan #(
            .DATAW     (DATAW),
            .DEPTH     (DEPTH),
            .AF_LEVEL  (AF_LEVEL),
            .STORE_FWD (STORE_FWD),
            .OCCW      (OCCW)
        ) u_chan (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_push   (w_push[c]),
            .i_entry  ({axis_rx_tlast, axis_rx_tdata}),
            .i_pop    (data_fifo_ren[c]),
            .o_entry  (w_head[c]),
            .o_rdy    (data_fifo_rdy[c]),
            .o_accept (w_accept[c])
        );

        assign data_fifo_rdata[c*DATAW +: DATAW] = w_head[c][DATAW-1:0];
        assign data_fifo_rlast[c]                = w_head[c][DATAW];
    end

endmodule

// File: tb/tb_collector_mc.sv
// Directed bench: one cut-through (index 0) and one store-and-forward
// (index 1) collector, each driven through its own stimulus signals.
module tb_collector_mc;

    logic          clk;
    logic          rst;
    logic          tv    [2];
    logic [511:0]  td    [2];
    logic [6:0]    tdst  [2];
    logic          tl    [2];
    logic          trdy  [2];
    logic [3:0]    ren   [2];
    logic [2047:0] rdata [2];
    logic [3:0]    rlast [2];
    logic [3:0]    rdy   [2];
    logic [31:0]   dcnt  [2];
    logic [7:0]    zero_b;
    logic [31:0]   zero_id;
    logic [74:0]   zero_u;

    int total;
    int bad;

    collector_mc #(.NUM_CH(4), .DEPTH(64), .STORE_FWD(0)) u_ct (
        .clk(clk), .rst(rst),
        .axis_rx_tvalid(tv[0]), .axis_rx_tdata(td[0]),
        .axis_rx_tstrb(zero_b), .axis_rx_tkeep(zero_b),
        .axis_rx_tid(zero_id), .axis_rx_tdest(tdst[0]),
        .axis_rx_tuser(zero_u), .axis_rx_tlast(tl[0]),
        .axis_rx_tready(trdy[0]), .data_fifo_ren(ren[0]),
        .data_fifo_rdata(rdata[0]), .data_fifo_rlast(rlast[0]),
        .data_fifo_rdy(rdy[0]), .drop_cnt(dcnt[0])
    );

    collector_mc #(.NUM_CH(4), .DEPTH(64), .STORE_FWD(1)) u_sf (
        .clk(clk), .rst(rst),
        .axis_rx_tvalid(tv[1]), .axis_rx_tdata(td[1]),
        .axis_rx_tstrb(zero_b), .axis_rx_tkeep(zero_b),
        .axis_rx_tid(zero_id), .axis_rx_tdest(tdst[1]),
        .axis_rx_tuser(zero_u), .axis_rx_tlast(tl[1]),
        .axis_rx_tready(trdy[1]), .data_fifo_ren(ren[1]),
        .data_fifo_rdata(rdata[1]), .data_fifo_rlast(rlast[1]),
        .data_fifo_rdy(rdy[1]), .drop_cnt(dcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for tready, complete it on the next edge.
    task automatic send(input int d, input logic [6:0] dst, input logic [511:0] data, input logic last);
        int n;
        n = 0;
        tv[d] = 1'b1; tdst[d] = dst; td[d] = data; tl[d] = last;
        #1;
        while (!trdy[d] && n < 100) begin
            tick();
            n++;
        end
        chk("send_accept_bound", 512'(n < 100), 512'(1));
        @(posedge clk);
        #1;
        tv[d] = 1'b0; tl[d] = 1'b0;
    endtask

    // Check the head of channel ch, then pop it.
    task automatic pop(input int d, input int ch, input logic [511:0] exp_d, input logic exp_l, input string tag);
        chk({tag, "_rdy"},  512'(rdy[d][ch]), 512'(1));
        chk({tag, "_data"}, rdata[d][ch*512 +: 512], exp_d);
        chk({tag, "_last"}, 512'(rlast[d][ch]), 512'(exp_l));
        ren[d][ch] = 1'b1;
        tick();
        ren[d] = 4'b0000;
    endtask

    initial begin
        total = 0; bad = 0;
        zero_b = 8'h00; zero_id = 32'h0; zero_u = 75'h0;
        for (int d = 0; d < 2; d++) begin
            tv[d] = 1'b0; td[d] = 512'h0; tdst[d] = 7'd0; tl[d] = 1'b0; ren[d] = 4'b0000;
        end
        rst = 1'b1;
        tv[0] = 1'b1;
        tick();
        chk("rst_tready", 512'(trdy[0]), 512'(0));
        chk("rst_rdy", 512'(rdy[0]), 512'(0));
        tick();
        tv[0] = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_rdy_ct", 512'(rdy[0]), 512'(0));
        chk("post_rst_rdy_sf", 512'(rdy[1]), 512'(0));
        chk("post_rst_drop", 512'(dcnt[0]), 512'(0));

        // 1: cut-through, three beats to channel 2
        send(0, 7'd2, 512'h11, 1'b0);
        chk("t1_rdy_after_first", 512'(rdy[0]), 512'(4'b0100));
        send(0, 7'd2, 512'h22, 1'b0);
        send(0, 7'd2, 512'h33, 1'b1);
        chk("t1_rdy_others", 512'(rdy[0]), 512'(4'b0100));
        pop(0, 2, 512'h11, 1'b0, "t1_pop0");
        pop(0, 2, 512'h22, 1'b0, "t1_pop1");
        pop(0, 2, 512'h33, 1'b1, "t1_pop2");
        chk("t1_empty", 512'(rdy[0]), 512'(0));

        // 2: store-and-forward, four-beat packet to channel 1
        for (int i = 1; i <= 3; i++) begin
            send(1, 7'd1, 512'(32'hA0 + i), 1'b0);
            chk("t2_rdy_before_last", 512'(rdy[1][1]), 512'(0));
        end
        send(1, 7'd1, 512'hA4, 1'b1);
        chk("t2_rdy_after_last", 512'(rdy[1][1]), 512'(1));
        for (int i = 1; i <= 4; i++) begin
            pop(1, 1, 512'(32'hA0 + i), 1'(i == 4), "t2_pop");
        end
        chk("t2_pkt_drained", 512'(rdy[1][1]), 512'(0));

        // 3: fill channel 0 to the almost-full level
        for (int i = 0; i < 62; i++) begin
            send(0, 7'd0, 512'(32'h300 + i), 1'b0);
        end
        tv[0] = 1'b1; tdst[0] = 7'd0; td[0] = 512'h3FF;
        #1;
        chk("t3_full_tready", 512'(trdy[0]), 512'(0));
        tick();
        chk("t3_full_tready_hold", 512'(trdy[0]), 512'(0));
        tv[0] = 1'b0;
        send(0, 7'd3, 512'h3C3, 1'b1);
        chk("t3_ch3_rdy", 512'(rdy[0][3]), 512'(1));
        pop(0, 0, 512'h300, 1'b0, "t3_pop_first");
        tdst[0] = 7'd0;
        #1;
        chk("t3_tready_after_pop", 512'(trdy[0]), 512'(1));
        for (int i = 1; i < 62; i++) begin
            pop(0, 0, 512'(32'h300 + i), 1'b0, "t3_drain");
        end
        pop(0, 3, 512'h3C3, 1'b1, "t3_ch3");
        chk("t3_all_empty", 512'(rdy[0]), 512'(0));

        // 4: out-of-range tdest beats are dropped and counted
        tv[0] = 1'b1; tdst[0] = 7'd5;
        #1;
        chk("t4_tready_dest5", 512'(trdy[0]), 512'(1));
        tv[0] = 1'b0;
        send(0, 7'd5, 512'h55, 1'b1);
        chk("t4_drop1", 512'(dcnt[0]), 512'(1));
        send(0, 7'd127, 512'h77, 1'b0);
        chk("t4_drop2", 512'(dcnt[0]), 512'(2));
        chk("t4_no_channel_data", 512'(rdy[0]), 512'(0));

        // 5: store-and-forward, simultaneous push and pop of last beats on channel 3
        send(1, 7'd3, 512'h51, 1'b1);
        chk("t5_rdy_before", 512'(rdy[1][3]), 512'(1));
        tv[1] = 1'b1; tdst[1] = 7'd3; td[1] = 512'h52; tl[1] = 1'b1; ren[1] = 4'b1000;
        #1;
        chk("t5_head_before", rdata[1][3*512 +: 512], 512'h51);
        chk("t5_tready_both", 512'(trdy[1]), 512'(1));
        tick();
        tv[1] = 1'b0; tl[1] = 1'b0; ren[1] = 4'b0000;
        chk("t5_rdy_after", 512'(rdy[1][3]), 512'(1));
        pop(1, 3, 512'h52, 1'b1, "t5_pop");
        chk("t5_empty", 512'(rdy[1][3]), 512'(0));

        // 6: 70-beat packet exercises the overflow escape
        for (int i = 1; i <= 61; i++) begin
            send(1, 7'd0, 512'(32'h600 + i), 1'b0);
        end
        chk("t6_rdy_at61", 512'(rdy[1][0]), 512'(0));
        send(1, 7'd0, 512'h63E, 1'b0);
        chk("t6_escape_rdy", 512'(rdy[1][0]), 512'(1));
        tdst[1] = 7'd0;
        #1;
        chk("t6_tready_full", 512'(trdy[1]), 512'(0));
        for (int i = 63; i <= 70; i++) begin
            pop(1, 0, 512'(32'h600 + i - 62), 1'b0, "t6_stream");
            send(1, 7'd0, 512'(32'h600 + i), 1'(i == 70));
        end
        for (int i = 9; i <= 70; i++) begin
            pop(1, 0, 512'(32'h600 + i), 1'(i == 70), "t6_drain");
        end
        chk("t6_drained", 512'(rdy[1]), 512'(0));

        // reset in the middle of a second packet
        send(1, 7'd9, 512'h99, 1'b0);
        chk("t6_drop_pre_rst", 512'(dcnt[1]), 512'(1));
        send(1, 7'd2, 512'h701, 1'b1);
        send(1, 7'd0, 512'h711, 1'b0);
        send(1, 7'd0, 512'h712, 1'b0);
        chk("t6_rdy_pre_rst", 512'(rdy[1]), 512'(4'b0100));
        rst = 1'b1;
        tv[1] = 1'b1; tdst[1] = 7'd0; td[1] = 512'h713;
        #1;
        chk("t6_rst_tready", 512'(trdy[1]), 512'(0));
        chk("t6_rst_rdy", 512'(rdy[1]), 512'(0));
        tick();
        chk("t6_rst_tready_edge", 512'(trdy[1]), 512'(0));
        chk("t6_rst_rdy_edge", 512'(rdy[1]), 512'(0));
        rst = 1'b0;
        tv[1] = 1'b0;
        #1;
        chk("t6_post_rst_rdy", 512'(rdy[1]), 512'(0));
        chk("t6_post_rst_drop", 512'(dcnt[1]), 512'(0));
        chk("t6_post_rst_tready", 512'(trdy[1]), 512'(1));
        send(1, 7'd0, 512'h777, 1'b1);
        pop(1, 0, 512'h777, 1'b1, "t6_post_rst_pop");
        chk("t6_post_rst_empty", 512'(rdy[1]), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collector_mc.md
Name: collector_mc

Overview:
- Multi-channel successor to the single-FIFO AXI-S receive collector.
- Accepts one AXI-S stream from the NoC and steers each beat by tdest into one of NUM_CH per-channel FIFOs, storing tlast with the data.
- Each channel has its own pop/ready read port for the downstream MVM datapath.
- Adds a store-and-forward mode (ready only once a complete packet is buffered), an overflow escape, and a counter for beats addressed to non-existent channels.

Parameters:
- DATAW, 512, tdata width and FIFO word width (a tlast bit is added internally).
- BYTEW, 8, tstrb/tkeep width.
- IDW, 32, tid width.
- DESTW, 7, tdest width.
- USERW, 75, tuser width.
- NUM_CH, 4, number of channels, 1..2^DESTW, not necessarily a power of 2.
- DEPTH, 64, words per channel FIFO; power of 2, ≥4.
- AF_LEVEL, DEPTH-2, occupancy at or above which a channel stops accepting beats.
- STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- axis_rx_tvalid  in  1  beat valid.
- axis_rx_tdata  in  DATAW  beat data.
- axis_rx_tstrb  in  BYTEW  ignored.
- axis_rx_tkeep  in  BYTEW  ignored.
- axis_rx_tid  in  IDW  ignored.
- axis_rx_tdest  in  DESTW  channel select; channel = tdest value.
- axis_rx_tuser  in  USERW  ignored.
- axis_rx_tlast  in  1  last beat of packet.
- axis_rx_tready  out  1  beat accepted when tvalid && tready.
- data_fifo_ren  in  NUM_CH  per-channel pop.
- data_fifo_rdata  out  NUM_CH*DATAW  head word of each channel; channel c occupies bits [c*DATAW +: DATAW].
- data_fifo_rlast  out  NUM_CH  tlast of each head word.
- data_fifo_rdy  out  NUM_CH  channel head valid and poppable.
- drop_cnt  out  32  count of dropped beats, saturating.

Behaviour:
- Reset (rst=1 at a clk edge): all FIFOs empty, all occupancy/packet counters 0, drop_cnt 0.
- While rst is high: axis_rx_tready=0 and data_fifo_rdy=0, combinationally.
- Routing:
  - sel = tdest.
  - sel < NUM_CH: tready = (occ[sel] < AF_LEVEL).
  - sel ≥ NUM_CH: tready = 1; an accepted beat is discarded and drop_cnt increments by 1, saturating at 2^32-1.
  - tready is combinational from tdest and registered occupancy only; it never depends on tvalid.
- Push: an accepted, in-range beat writes {tlast, tdata} into channel sel on that edge. It is visible at the head (rdy=1) on the next cycle.
- FIFO read is show-ahead: rdata/rlast show the head whenever occ>0. A pop with ren[c]=1 and rdy[c]=1 advances the head on that edge.
- Invalid pops: ren[c]=1 while rdy[c]=0 is ignored, with no state change. This includes a pop on an empty channel.
- Occupancy occ[c] (width clog2(DEPTH+1)):
  - +1 on push, -1 on pop.
  - Push and pop on the same channel in the same cycle: unchanged; both take effect.
  - Because AF_LEVEL ≤ DEPTH-1, overflow is impossible; no full handling is required beyond tready.
- Packet count pkt[c] (width clog2(DEPTH+1)):
  - +1 on push of a tlast=1 beat.
  - -1 on pop of a head with rlast=1.
  - Both in the same cycle: unchanged.
- Ready rules:
  - STORE_FWD=0: rdy[c] = (occ[c]>0).
  - STORE_FWD=1: rdy[c] = (pkt[c]>0) || (occ[c] ≥ AF_LEVEL).
  - The second term is the overflow escape: it streams out a packet longer than AF_LEVEL so the channel cannot deadlock.
  - Once the escape fires mid-packet, rdy[c] still follows this equation each cycle; it is not latched.
- Latency: push to rdy is 1 cycle in cut-through mode, and 1 cycle after the tlast push in store-and-forward mode.
- Ordering and independence:
  - Per-channel order is preserved.
  - No ordering across channels.
  - A full channel blocks only beats destined to it; the stream stalls at that beat.
- Reset mid-packet: partial packets are discarded. The upstream packet continues into the empty FIFOs after reset. A headless tail can therefore reach the consumer; this is accepted.
- Unconstrained: tdata/tlast while tvalid=0.

Decomposition:
- Package collector_mc_pkg holds:
  - function for the occupancy counter width, clog2(DEPTH+1);
  - typedef of the FIFO entry struct {last, data};
  - constant DROP_CNT_W = 32.
- Sub-module collector_chan, instantiated NUM_CH times, holds:
  - one FIFO (the existing fifo module, width DATAW+1);
  - the occ/pkt counters;
  - the rdy logic.
  - Ports: push, entry in, pop, entry out, rdy, accept (occ<AF_LEVEL).
- The top level holds the tdest decode, tready mux, drop counter and rdata flattening.

Test Plan:
1. STORE_FWD=0, NUM_CH=4: send 3 beats to tdest=2 (data 0x11, 0x22, 0x33, last on 0x33). Required: rdy[2]=1 one cycle after the first accept; pops return 0x11, 0x22, 0x33 with rlast=0,0,1; rdy[0,1,3] stay 0.
2. STORE_FWD=1: send 4 beats to channel 1 with tlast on beat 4. Required: rdy[1]=0 through beat 3 and =1 the cycle after beat 4; pkt[1] returns to 0 after the 4th pop.
3. Hold ren=0 and stream to channel 0, DEPTH=64, AF_LEVEL=62. Required: exactly 62 beats accepted, then tready=0 while tdest=0; a beat to tdest=3 is still accepted. One pop on channel 0 gives tready=1 the next cycle.
4. Beats with tdest=5 and tdest=127 (NUM_CH=4). Required: tready=1, drop_cnt increments 0→1→2, no channel's occupancy changes.
5. Simultaneous push and pop on channel 3 at occ=1, STORE_FWD=1, where the popped head has rlast=1 and the pushed beat has tlast=1. Required: occ=1 and pkt=1 unchanged, rdy[3] stays 1.
6. STORE_FWD=1, 70-beat packet with no early tlast. Required: the escape asserts rdy at occ=62; all 70 beats drain in order with rlast only on beat 70. Then assert rst mid-second-packet: required: next cycle rdy=0 and tready=0 during reset, occ=0, drop_cnt=0 after reset.
